// File: rtl/ring_buffer_ctrl_pkg.sv
// Shared types for the ring buffer controller: FSM states, op kinds, word/address types.
// No logic beyond a small address helper.
package ring_buffer_ctrl_pkg;

    typedef logic [15:0] word_t;
    typedef logic [7:0]  addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_READ,
        ST_READ_WAIT,
        ST_RELEASE
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Ring addresses live in an 8-bit space; the sum wraps with it.
    function automatic addr_t ring_addr(input addr_t base, input addr_t offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/ring_buffer_ctrl_ptr.sv
// Purpose: ring write/read pointers, occupancy count, full/empty flags and memory addresses.
// Latency: pointer increments visible one cycle after wr_inc/rd_inc; flags are combinational from the pointers.
// Backpressure: none here; the caller only increments when the ring has room/data.
module ring_ptr_ctrl
    import ring_buffer_ctrl_pkg::*;
#(
    parameter addr_t BASE_ADDR = 8'h00,
    parameter int    DEPTH     = 64,
    localparam int   AW        = $clog2(DEPTH),
    localparam int   PW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_inc,
    input  logic          rd_inc,
    output logic [PW-1:0] count,
    output logic          full,
    output logic          empty,
    output addr_t         wr_addr,
    output addr_t         rd_addr
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_inc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_addr = ring_addr(BASE_ADDR, addr_t'(wr_ptr[AW-1:0]));
    assign rd_addr = ring_addr(BASE_ADDR, addr_t'(rd_ptr[AW-1:0]));

endmodule

// File: rtl/ring_buffer_ctrl.sv
// Purpose: single-word in/out holds feeding a ring in arbitrated shared memory, one memory op per grant.
// Latency: write = REQ+WRITE after grant; read = REQ+READ+READ_WAIT after grant, data lands in out_hold.
// Backpressure: in_ready drops while in_hold is occupied (it stays occupied while the ring is full); out_valid holds until out_ready.
module ring_buffer_ctrl
    import ring_buffer_ctrl_pkg::*;
#(
    parameter addr_t BASE_ADDR = 8'h00,
    parameter int    DEPTH     = 64,
    localparam int   PW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  word_t         in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output word_t         out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          request,
    input  logic          grant,
    output addr_t         mem_addr,
    output word_t         mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  word_t         mem_rdata,
    output logic [PW-1:0] count,
    output logic          full,
    output logic          empty
);

    state_t state;
    state_t state_nxt;
    op_t    last_op;
    word_t  in_hold;
    word_t  out_hold;
    logic   in_hold_vld;
    logic   out_hold_vld;
    logic   wr_inc;
    logic   rd_inc;
    logic   wr_pend;
    logic   rd_pend;
    addr_t  wr_addr;
    addr_t  rd_addr;

    ring_ptr_ctrl #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .wr_inc  (wr_inc),
        .rd_inc  (rd_inc),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr)
    );

    assign wr_pend   = in_hold_vld && !full;
    assign rd_pend   = !out_hold_vld && !empty;
    assign in_ready  = !in_hold_vld;
    assign out_valid = out_hold_vld;
    assign out_data  = out_hold;
    assign wr_inc    = (state == ST_WRITE);
    assign rd_inc    = (state == ST_READ_WAIT);
    assign mem_addr  = (state == ST_READ) ? rd_addr : wr_addr;
    assign mem_wdata = (state == ST_WRITE) ? in_hold : '0;

    always_comb begin
        state_nxt = state;
        request   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_pend || rd_pend) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                request = 1'b1;
                if (grant) begin
                    // On a tie, alternate against the last completed op so neither side starves.
                    if (wr_pend && (!rd_pend || last_op == OP_READ)) state_nxt = ST_WRITE;
                    else if (rd_pend)                                state_nxt = ST_READ;
                    else                                             state_nxt = ST_RELEASE;
                end
            end
            ST_WRITE: begin
                request   = 1'b1;
                mem_we    = 1'b1;
                state_nxt = ST_RELEASE;
            end
            ST_READ: begin
                request   = 1'b1;
                mem_re    = 1'b1;
                state_nxt = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                request   = 1'b1;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!grant) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_op      <= OP_READ;
            in_hold      <= '0;
            in_hold_vld  <= 1'b0;
            out_hold     <= '0;
            out_hold_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_WRITE) begin
                in_hold_vld <= 1'b0;
                last_op     <= OP_WRITE;
            end else if (in_valid && !in_hold_vld) begin
                in_hold     <= in_data;
                in_hold_vld <= 1'b1;
            end
            // READ_WAIT only runs with out_hold empty, so capture never collides with a take.
            if (state == ST_READ_WAIT) begin
                out_hold     <= mem_rdata;
                out_hold_vld <= 1'b1;
                last_op      <= OP_READ;
            end else if (out_ready && out_hold_vld) begin
                out_hold_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Bench for ring_buffer_ctrl (DEPTH=4): memory and arbiter responders, a FIFO-order scoreboard
// with occupancy bookkeeping, directed scenarios and a randomized phase.
module tb_ring_buffer_ctrl;
    import ring_buffer_ctrl_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [7:0]  BASE  = 8'h00;
    localparam int          PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    word_t         in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    word_t         out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          request;
    logic          grant = 1'b0;
    addr_t         mem_addr;
    word_t         mem_wdata;
    logic          mem_we;
    logic          mem_re;
    word_t         mem_rdata = '0;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    ring_buffer_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .request(request), .grant(grant),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shared memory: read data appears the cycle after mem_re.
    word_t mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Arbiter: grants grant_delay+1 cycles after request rises, holds while request is high,
    // then lingers grant_linger extra cycles after request drops.
    int grant_delay = 0;
    int grant_linger = 0;
    int req_age = 0;
    int linger_cnt = 0;
    always @(negedge clk) begin
        if (request) begin
            linger_cnt = 0;
            req_age++;
            if (req_age > grant_delay + 1) grant = 1'b1;
        end else begin
            req_age = 0;
            if (grant && linger_cnt < grant_linger) linger_cnt++;
            else begin
                grant = 1'b0;
                linger_cnt = 0;
            end
        end
    end

    // Reference model: accepted words in order; ring occupancy = written - completed reads.
    word_t acc_q[$];
    int    op_log[$];
    int    wr_n = 0, rd_iss = 0, rd_done = 0, rd_stage = 0, out_n = 0, ops_in_grant = 0;
    logic  req_prev = 1'b0, grant_prev = 1'b0, rst_prev = 1'b1, aborted = 1'b0;
    logic [PW-1:0] exp_cnt;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            acc_q.delete();
            wr_n = 0; rd_iss = 0; rd_done = 0; rd_stage = 0; out_n = 0;
            if (grant) aborted = 1'b1;
        end else begin
            if (rd_stage != 0) begin
                rd_stage--;
                if (rd_stage == 0) rd_done++;
            end
            exp_cnt = PW'(wr_n - rd_done);
            chk("occupancy_le_depth", 32'(wr_n - rd_done <= DEPTH), 1);
            chk("count", count, exp_cnt);
            chk("full", full, (wr_n - rd_done) == DEPTH);
            chk("empty", empty, (wr_n - rd_done) == 0);
            chk("in_ready", in_ready, acc_q.size() == wr_n);
            chk("out_valid", out_valid, rd_done != out_n);
            chk("we_re_exclusive", mem_we && mem_re, 0);
            if (mem_we || mem_re) chk("op_under_grant", grant, 1);
            if (request && !req_prev && !rst_prev) chk("req_rise_grant_low", grant, 0);
            if (!request && req_prev && !rst_prev) chk("req_fall_after_grant", grant_prev, 1);
            if (mem_we) begin
                chk("wr_addr", mem_addr, (BASE + wr_n % DEPTH) & 8'hff);
                if (wr_n < acc_q.size()) chk("wr_data", mem_wdata, acc_q[wr_n]);
                else chk("wr_without_word", mem_we, 0);
                wr_n++;
                ops_in_grant++;
                op_log.push_back(1);
            end
            if (mem_re) begin
                chk("rd_addr", mem_addr, (BASE + rd_iss % DEPTH) & 8'hff);
                rd_iss++;
                rd_stage = 2;
                ops_in_grant++;
                op_log.push_back(0);
            end
            if (out_valid && out_ready) begin
                if (out_n < acc_q.size()) chk("out_data_order", out_data, acc_q[out_n]);
                else chk("out_without_word", out_valid, 0);
                out_n++;
            end
            if (in_valid && in_ready) acc_q.push_back(in_data);
        end
        if (grant && !grant_prev) begin
            ops_in_grant = 0;
            aborted = 1'b0;
        end
        if (!grant && grant_prev && !aborted) chk("one_op_per_grant", ops_in_grant, 1);
        req_prev = request; grant_prev = grant; rst_prev = rst;
    end

    task automatic push(input word_t w);
        int n;
        @(negedge clk);
        in_data = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int target);
        int t;
        t = 0;
        while (out_n < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, out_n, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_request", request, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst = 1'b0;

        // Single word through an empty ring; arbiter grants one cycle after request.
        @(negedge clk);
        in_data = 16'hABCD;
        in_valid = 1'b1;
        chk("a_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_out_valid", out_valid, 1);
        chk("a_latency_min", 32'(n >= 6), 1);
        chk("a_out_data", out_data, 16'hABCD);
        chk("a_count_zero", count, 0);
        chk("a_empty", empty, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("a_out_taken", out_valid, 0);

        // Fill with the output stalled: ring full, both holds occupied.
        do_reset();
        for (int i = 0; i < 6; i++) push(word_t'(16'h1000 + i));
        repeat (30) @(negedge clk);
        chk("b_full", full, 1);
        chk("b_count", count, DEPTH);
        chk("b_in_ready_low", in_ready, 0);
        chk("b_out_valid", out_valid, 1);
        chk("b_out_first", out_data, 16'h1000);
        out_ready = 1'b1;
        wait_out("b_drain", 6);
        chk("b_empty_after", empty, 1);

        // Stream past the wrap point with the output always ready.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(word_t'(16'h2000 + 3 * i));
        wait_out("c_stream", 10);
        chk("c_writes", wr_n, 10);

        // Slow grants: ops alternate write/read, starting with a write.
        do_reset();
        grant_delay = 5;
        op_log.delete();
        for (int i = 0; i < 8; i++) push(word_t'(16'h3000 + i));
        wait_out("d_stream", 8);
        chk("d_op_total", op_log.size(), 16);
        if (op_log.size() > 0) chk("d_first_write", op_log[0], 1);
        for (int i = 1; i < op_log.size(); i++) chk("d_alternate", 32'(op_log[i] != op_log[i-1]), 1);
        grant_delay = 0;

        // Reset while a read is in flight.
        do_reset();
        out_ready = 1'b0;
        push(16'h4444);
        n = 0;
        while (!mem_re && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("e_saw_read", mem_re, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("e_request", request, 0);
        chk("e_out_valid", out_valid, 0);
        chk("e_count", count, 0);
        chk("e_mem_re", mem_re, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("e_idle_request", request, 0);

        // Randomized traffic with varying grant delay and linger.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = word_t'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (c % 40 == 0) begin
                grant_delay  = $urandom_range(0, 4);
                grant_linger = $urandom_range(0, 3);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_n == acc_q.size() && in_ready && empty && !out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("f_drain_all", out_n, acc_q.size());
        chk("f_final_empty", empty, 1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_buffer_ctrl.md
RING_BUFFER_CTRL -- requirements
Module: ring_buffer_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first memory word of the ring region.
REQ-002 SHALL have parameter DEPTH, default 64: ring size in 16-bit words, power of two, 2..128.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_data  in  16, in_valid  in  1, in_ready  out  1; word transfers when in_valid && in_ready.
REQ-006 SHALL have ports: out_data  out  16, out_valid  out  1, out_ready  in  1; word transfers when out_valid && out_ready.
REQ-007 SHALL have ports: request  out  1, grant  in  1; client side of the shared-memory arbiter.
REQ-008 SHALL have ports: mem_addr  out  8, mem_wdata  out  16, mem_we  out  1, mem_re  out  1, mem_rdata  in  16; mem_rdata valid the cycle after mem_re.
REQ-009 SHALL have ports: count  out  clog2(DEPTH)+1, full  out  1, empty  out  1.

Function
REQ-010 SHALL hold one input word in in_hold; in_ready = !in_hold_valid.
REQ-011 SHALL hold one output word in out_hold; out_valid = out_hold_valid; out_data = out_hold.
REQ-012 SHALL keep wr_ptr, rd_ptr of clog2(DEPTH)+1 bits; count = wr_ptr - rd_ptr mod 2^(clog2(DEPTH)+1); full = (count == DEPTH); empty = (count == 0).
REQ-013 SHALL form mem_addr = BASE_ADDR + ptr[clog2(DEPTH)-1:0], truncated to 8 bits; pointers wrap naturally at DEPTH.
REQ-014 SHALL run FSM IDLE, REQ, WRITE, READ, READ_WAIT, RELEASE.
REQ-015 IDLE: write pending = in_hold_valid && !full; read pending = !out_hold_valid && !empty; either pending -> REQ with request=1.
REQ-016 REQ: request held high until grant=1; on grant, go WRITE or READ per REQ-017.
REQ-017 Both pending at grant: choose op opposite to last completed op (last_op reset = READ, so write first); one pending: that op.
REQ-018 WRITE: one cycle, mem_we=1, mem_addr from wr_ptr, mem_wdata=in_hold; wr_ptr++, in_hold_valid cleared; -> RELEASE.
REQ-019 READ: one cycle, mem_re=1, mem_addr from rd_ptr; -> READ_WAIT.
REQ-020 READ_WAIT: capture mem_rdata into out_hold, set out_hold_valid, rd_ptr++; -> RELEASE.
REQ-021 Exactly one memory transaction per grant; request falls on entry to RELEASE.
REQ-022 RELEASE: request=0; stay until grant=0, then IDLE; no new request while grant is high.
REQ-023 mem_we, mem_re SHALL never be high outside WRITE/READ and never both high.
REQ-024 Upstream accept and downstream take SHALL operate in any state, simultaneously in same cycle, independent of FSM.
REQ-025 Full: write not pending, in_hold keeps word, in_ready stays 0 until a read frees space.
REQ-026 Empty: no read request; out_valid stays 0.
REQ-027 Latency: word into empty ring with grant granted 1 cycle after request -> out_valid 6 cycles after in_valid&&in_ready sampled, minimum.

Reset
REQ-028 rst SHALL clear wr_ptr, rd_ptr, in_hold_valid, out_hold_valid, last_op=READ, FSM=IDLE.
REQ-029 Reset values: request=0, mem_we=0, mem_re=0, mem_addr=BASE_ADDR, mem_wdata=0, in_ready=1, out_valid=0, out_data=0, count=0, empty=1, full=0.
REQ-030 rst mid-transaction SHALL abort at once: request drops same edge, partial read data discarded, ring contents treated as lost.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, op-kind enum (OP_READ, OP_WRITE), and the 16-bit word and 8-bit address typedefs.
REQ-032 Pointer/count logic SHALL be one sub-module ring_ptr_ctrl (wr_ptr, rd_ptr, count, full, empty, address generation); FSM and hold registers stay in ring_buffer_ctrl.

Verification
REQ-033 Push 16'hABCD into empty ring, grant 1 cycle after each request -> mem_we at addr 8'h00 data 16'hABCD, then mem_re at 8'h00, out_data=16'hABCD, count returns 0.
REQ-034 DEPTH=4, out_ready=0, push 6 words -> 4 written to 8'h00..8'h03, then 1 more read into out_hold; full=1 with count=4; in_ready=0 once in_hold also filled.
REQ-035 Stream 10 words through DEPTH=4 with out_ready=1 -> addresses wrap 03->00, output order equals input order.
REQ-036 Hold both pending, delay grant 5 cycles -> request high throughout, one op per grant, ops alternate write/read, request low at least until grant falls.
REQ-037 Assert rst during READ_WAIT -> next cycle request=0, out_valid=0, count=0, FSM IDLE.
REQ-038 Bench SHALL assert every cycle: !(mem_we && mem_re), and mem_we/mem_re only while grant=1.
